// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, execute redirect,
// decode handshake and status outputs of the fetch unit.
//
// Handshake: a word moves from fetch to decode on a rising edge where
// id_valid=1 and id_ready=1. While id_valid=1 and id_ready=0, id_instr,
// id_pc and id_pc_plus4 are held stable. id_valid never depends
// combinationally on id_ready.
interface instruction_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] instr_count;
    logic        dbg_state;   // current FSM state (0 = RUN, 1 = HALT)

    // Fetch unit side
    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_target,
        input  halt_req,
        input  id_ready,
        output id_valid,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        output halted,
        output fault,
        output instr_count,
        output dbg_state
    );

    // Environment side: memory, execute, decode
    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_target,
        output halt_req,
        output id_ready,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        input  halted,
        input  fault,
        input  instr_count,
        input  dbg_state
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory,
// captures the returned word into the IF/ID register and hands it to
// decode. Redirects flush the IF/ID slot; halt requests, misaligned
// redirects and out-of-range fetches park the unit in HALT until reset.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IMEM_LAST = 200
) (
    input  logic                          clk,
    input  logic                          rst_n,
    instruction_fetch_unit_if.master      bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic        accept;
    logic        handshake;
    logic        redirect_misaligned;
    logic        fetch_past_end;
    logic [32:0] fetch_end;

    // Slot is free, or its occupant leaves on this edge.
    assign accept    = ~id_valid_q | bus.id_ready;
    assign handshake = id_valid_q & bus.id_ready;

    assign redirect_misaligned = (bus.redirect_target[1:0] != 2'b00);

    // Range check done one bit wider so pc values near 2^32 cannot wrap
    // into the legal window.
    assign fetch_end      = {1'b0, pc_q} + 33'd3;
    assign fetch_past_end = (fetch_end > 33'(IMEM_LAST));

    // Next-state logic: RUN priority is halt, bad redirect, redirect,
    // out-of-range fetch, capture, stall.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fault_d       = fault_q;
        count_d       = count_q + 32'(handshake);

        case (state_q)
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d    = ST_HALT;
                    id_valid_d = 1'b0;
                end else if (bus.redirect_valid && redirect_misaligned) begin
                    state_d    = ST_HALT;
                    fault_d    = 1'b1;
                    id_valid_d = 1'b0;
                end else if (bus.redirect_valid) begin
                    // Flush the wrong-path word; the target is fetched next edge.
                    pc_d       = bus.redirect_target;
                    id_valid_d = 1'b0;
                end else if (accept && fetch_past_end) begin
                    state_d    = ST_HALT;
                    fault_d    = 1'b1;
                    id_valid_d = 1'b0;
                end else if (accept) begin
                    id_instr_d    = bus.imem_instr;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_q + 32'd4;
                    id_valid_d    = 1'b1;
                    pc_d          = pc_q + 32'd4;
                end
            end
            ST_HALT: begin
                // Absorbing: only reset leaves HALT.
                id_valid_d = 1'b0;
            end
            default: begin
                state_d    = ST_HALT;
                id_valid_d = 1'b0;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            count_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.instr_count = count_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: byte memory model, directed
// scenarios pinned with literal values, then randomized traffic checked
// every cycle against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

    localparam int unsigned IMEM_LAST = 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_LAST (IMEM_LAST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.id_ready        = id_ready;
    assign bus.redirect_valid  = redirect_valid;
    assign bus.redirect_target = redirect_target;
    assign bus.halt_req        = halt_req;

    // ---------------- instruction memory ----------------
    logic [7:0] mem [256];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a <= 32'd252)
            return {mem[a[7:0]], mem[a[7:0] + 8'd1], mem[a[7:0] + 8'd2], mem[a[7:0] + 8'd3]};
        else
            return 32'hDEAD_BEEF;
    endfunction

    always_comb bus.imem_instr = word_at(bus.imem_addr);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_id_pc, m_link, m_count;
    bit          m_valid, m_halted, m_fault;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 32'd0; m_instr = 32'd0; m_id_pc = 32'd0; m_link = 32'd0;
            m_count = 32'd0; m_valid = 0; m_halted = 0; m_fault = 0;
        end else begin
            if (m_valid && id_ready) m_count = m_count + 32'd1;
            if (!m_halted) begin
                if (halt_req) begin
                    m_halted = 1; m_valid = 0;
                end else if (redirect_valid && (redirect_target % 4 != 0)) begin
                    m_halted = 1; m_fault = 1; m_valid = 0;
                end else if (redirect_valid) begin
                    m_pc = redirect_target; m_valid = 0;
                end else if (!m_valid || id_ready) begin
                    if (longint'(m_pc) + 3 > longint'(IMEM_LAST)) begin
                        m_halted = 1; m_fault = 1; m_valid = 0;
                    end else begin
                        m_instr = word_at(m_pc);
                        m_id_pc = m_pc;
                        m_link  = m_pc + 32'd4;
                        m_valid = 1;
                        m_pc    = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("imem_addr",   bus.imem_addr,           m_pc);
            chk("id_valid",    32'(bus.id_valid),       32'(m_valid));
            chk("id_instr",    bus.id_instr,            m_instr);
            chk("id_pc",       bus.id_pc,               m_id_pc);
            chk("id_pc_plus4", bus.id_pc_plus4,         m_link);
            chk("halted",      32'(bus.halted),         32'(m_halted));
            chk("fault",       32'(bus.fault),          32'(m_fault));
            chk("instr_count", bus.instr_count,         m_count);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit rdy, input bit rv, input logic [31:0] tgt, input bit hr);
        id_ready        = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        halt_req        = hr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 32'd0, 0);
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst_n = 1'b0;
        drive(0, 0, 32'd0, 0);

        // T1 reset
        do_reset();
        check_en = 1'b1;
        chk("t1_imem_addr", bus.imem_addr, 32'd0);
        chk("t1_id_valid", 32'(bus.id_valid), 32'd0);
        chk("t1_halted", 32'(bus.halted), 32'd0);
        chk("t1_fault", 32'(bus.fault), 32'd0);
        chk("t1_count", bus.instr_count, 32'd0);

        // T2 stream of three words
        drive(1, 0, 32'd0, 0);
        tick();
        chk("t2_pc0", bus.id_pc, 32'd0);
        chk("t2_instr0", bus.id_instr, 32'h0001_0203);
        tick();
        chk("t2_pc4", bus.id_pc, 32'd4);
        chk("t2_instr4", bus.id_instr, 32'h0405_0607);
        chk("t2_link4", bus.id_pc_plus4, 32'd8);
        tick();
        chk("t2_pc8", bus.id_pc, 32'd8);
        chk("t2_instr8", bus.id_instr, 32'h0809_0A0B);
        chk("t2_count", bus.instr_count, 32'd2);

        // T3 stall then release
        drive(0, 0, 32'd0, 0);
        repeat (4) tick();
        chk("t3_hold_pc", bus.id_pc, 32'd8);
        chk("t3_hold_addr", bus.imem_addr, 32'd12);
        drive(1, 0, 32'd0, 0);
        tick();
        chk("t3_release_pc", bus.id_pc, 32'd12);
        chk("t3_count", bus.instr_count, 32'd3);

        // T4 redirect while stalled, then misaligned redirect
        drive(0, 1, 32'h40, 0);
        tick();
        chk("t4_flush", 32'(bus.id_valid), 32'd0);
        chk("t4_addr", bus.imem_addr, 32'h40);
        drive(1, 0, 32'd0, 0);
        tick();
        chk("t4_target_pc", bus.id_pc, 32'h40);
        chk("t4_target_instr", bus.id_instr, 32'h4041_4243);
        drive(1, 1, 32'h42, 0);
        tick();
        chk("t4_halted", 32'(bus.halted), 32'd1);
        chk("t4_fault", 32'(bus.fault), 32'd1);

        // T6 halt request then reset
        do_reset();
        chk("t6_reset_count", bus.instr_count, 32'd0);
        drive(1, 0, 32'd0, 0);
        repeat (4) tick();
        chk("t6_addr", bus.imem_addr, 32'h10);
        drive(1, 0, 32'd0, 1);
        tick();
        chk("t6_halted", 32'(bus.halted), 32'd1);
        chk("t6_fault", 32'(bus.fault), 32'd0);
        chk("t6_valid", 32'(bus.id_valid), 32'd0);
        chk("t6_count", bus.instr_count, 32'd4);
        do_reset();
        chk("t6_post_halted", 32'(bus.halted), 32'd0);
        chk("t6_post_addr", bus.imem_addr, 32'd0);
        chk("t6_post_count", bus.instr_count, 32'd0);

        // T5 run off the end of memory
        drive(1, 1, 32'd184, 0);
        tick();
        drive(1, 0, 32'd0, 0);
        repeat (4) tick();
        chk("t5_last_pc", bus.id_pc, 32'd196);
        chk("t5_addr", bus.imem_addr, 32'd200);
        tick();
        chk("t5_halted", 32'(bus.halted), 32'd1);
        chk("t5_fault", 32'(bus.fault), 32'd1);
        chk("t5_held_pc", bus.id_pc, 32'd196);
        drive(1, 1, 32'd0, 0);
        repeat (2) tick();
        chk("t5_ignored_addr", bus.imem_addr, 32'd200);
        chk("t5_still_halted", 32'(bus.halted), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [31:0] tgt;
            rst_n = !(($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 7) == 0));
            tgt = 32'($urandom_range(0, 63)) * 32'd4;
            if ($urandom_range(0, 9) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, tgt,
                  $urandom_range(0, 199) == 0);
            tick();
        end
        rst_n = 1'b1;
        drive(0, 0, 32'd0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
